// File: rtl/jtopl_lfo.sv
// jtopl_lfo: OPL low-frequency oscillator providing the vibrato phase and
// the tremolo attenuation level.
//
// A sample tick is cen && zero. A free-running sample counter divides the
// tick rate down: vibrato steps once every 2^VIB_DIV_W ticks, and tremolo
// steps once every 2^TREM_DIV_W ticks. In fast (test) mode every tick steps
// both. Tremolo runs a position counter over TREM_STEPS positions and folds
// it into a triangle, which is scaled by the selected depth.
//
// Handshake: none. All state advances only in cycles where cen is high.
// lfo_clr is sampled with cen and takes priority over any tick.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   cen      in   clock enable
//   zero     in   sample-frame marker
//   lfo_clr  in   synchronous clear of all LFO state (qualified by cen)
//   fast     in   test mode: every tick steps vibrato and tremolo
//   am_dep   in   tremolo depth: 1 = deep (tri>>2), 0 = shallow (tri>>4)
//   vib_cnt  out  3-bit vibrato phase
//   trem     out  5-bit tremolo attenuation
module jtopl_lfo #(
  parameter int VIB_DIV_W  = 10,
  parameter int TREM_DIV_W = 6,
  parameter int TREM_STEPS = 210
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic       lfo_clr,
  input  logic       fast,
  input  logic       am_dep,
  output logic [2:0] vib_cnt,
  output logic [4:0] trem
);

  localparam logic [7:0] TREM_FULL = 8'(TREM_STEPS);
  localparam logic [7:0] TREM_HALF = 8'(TREM_STEPS / 2);
  localparam logic [7:0] TREM_LAST = 8'(TREM_STEPS - 1);

  logic [VIB_DIV_W-1:0] smp_cnt;
  logic [7:0]           trem_pos;
  logic                 tick;
  logic                 vib_step;
  logic                 trem_step;
  logic [7:0]           tri_val;
  logic [7:0]           tri_shift;
  logic                 unused_shift_bits;

  always_comb begin
    tick      = cen & zero;
    vib_step  = tick & (fast | (&smp_cnt));
    trem_step = tick & (fast | (&smp_cnt[TREM_DIV_W-1:0]));
    // Fold the position into a triangle: rising for the first half of the
    // period, falling back toward zero for the second half.
    tri_val   = (trem_pos < TREM_HALF) ? trem_pos : (TREM_FULL - trem_pos);
    tri_shift = am_dep ? (tri_val >> 2) : (tri_val >> 4);
  end

  // Upper bits of the shifted triangle are always zero for legal
  // TREM_STEPS; they are collected here only so they are not left dangling.
  assign unused_shift_bits = ^tri_shift[7:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt  <= '0;
      vib_cnt  <= '0;
      trem_pos <= '0;
      trem     <= '0;
    end else if (cen) begin
      if (lfo_clr) begin
        smp_cnt  <= '0;
        vib_cnt  <= '0;
        trem_pos <= '0;
        trem     <= '0;
      end else begin
        if (tick) begin
          smp_cnt <= smp_cnt + 1'b1;
        end
        if (vib_step) begin
          vib_cnt <= vib_cnt + 3'd1;
        end
        if (trem_step) begin
          trem_pos <= (trem_pos == TREM_LAST) ? 8'd0 : trem_pos + 8'd1;
        end
        // trem follows trem_pos/am_dep with one enabled cycle of latency.
        trem <= tri_shift[4:0];
      end
    end
  end

endmodule

// File: tb/tb_jtopl_lfo.sv
// tb_jtopl_lfo: self-checking bench for jtopl_lfo at default parameters.
// A tick-level reference model (sample count, vibrato phase, tremolo
// position, tremolo level) is advanced once per enabled cycle and compared
// with the DUT outputs every cycle, plus directed checks at key points.
module tb_jtopl_lfo;

  localparam int SMP_MOD  = 1024;
  localparam int TREM_DIV = 64;
  localparam int STEPS    = 210;

  logic       clk;
  logic       rst_n;
  logic       cen;
  logic       zero;
  logic       lfo_clr;
  logic       fast;
  logic       am_dep;
  logic [2:0] vib_cnt;
  logic [4:0] trem;

  int n_pass;
  int n_total;

  int smp_m;
  int vib_m;
  int pos_m;
  int trem_m;

  jtopl_lfo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .zero    (zero),
    .lfo_clr (lfo_clr),
    .fast    (fast),
    .am_dep  (am_dep),
    .vib_cnt (vib_cnt),
    .trem    (trem)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int tri_of(input int p);
    int up;
    int down;
    up   = p;
    down = STEPS - p;
    return (up < down) ? up : down;
  endfunction

  task automatic model_reset();
    smp_m  = 0;
    vib_m  = 0;
    pos_m  = 0;
    trem_m = 0;
  endtask

  // Drive one cycle, advance the model at the edge, check outputs after it.
  task automatic cycle(input bit c, input bit z, input bit clr, input bit f, input bit am);
    bit vstep;
    bit tstep;
    cen     = c;
    zero    = z;
    lfo_clr = clr;
    fast    = f;
    am_dep  = am;
    @(posedge clk);
    if (c) begin
      if (clr) begin
        model_reset();
      end else begin
        trem_m = am ? (tri_of(pos_m) / 4) : (tri_of(pos_m) / 16);
        if (z) begin
          vstep = f || (smp_m == SMP_MOD - 1);
          tstep = f || ((smp_m % TREM_DIV) == TREM_DIV - 1);
          smp_m = (smp_m + 1) % SMP_MOD;
          if (vstep) vib_m = (vib_m + 1) % 8;
          if (tstep) pos_m = (pos_m + 1) % STEPS;
        end
      end
    end
    #1;
    check("vib_cnt", 32'(vib_cnt), 32'(vib_m));
    check("trem", 32'(trem), 32'(trem_m));
  endtask

  initial begin
    int peak;
    int guard;
    int snap_vib;
    int snap_trem;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    cen     = 1'b0;
    zero    = 1'b0;
    lfo_clr = 1'b0;
    fast    = 1'b0;
    am_dep  = 1'b0;
    model_reset();
    #23;
    check("reset_vib", 32'(vib_cnt), 32'd0);
    check("reset_trem", 32'(trem), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Slow vibrato: one step per 1024 ticks, full cycle in 8192.
    for (int i = 1; i <= 8192; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if (i == 1023) check("vib_before_1024", 32'(vib_cnt), 32'd0);
      if (i == 1024) check("vib_after_1024", 32'(vib_cnt), 32'd1);
      if (i == 8192) check("vib_after_8192", 32'(vib_cnt), 32'd0);
    end

    // Fast tremolo sweep over one full period.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    peak = 0;
    for (int i = 0; i < STEPS; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      if (int'(trem) > peak) peak = int'(trem);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("trem_peak", 32'(peak), 32'd26);
    check("trem_period_end", 32'(trem), 32'd0);

    // Depth switch at position 100.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("trem_deep_100", 32'(trem), 32'd25);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("trem_shallow_100", 32'(trem), 32'd6);

    // Clear coinciding with a tick at vib=5, pos=150.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 149; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    guard = 0;
    while (pos_m != 150 && guard < 200) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    check("setup_pos_reached", 32'(pos_m), 32'd150);
    check("vib_before_clr", 32'(vib_cnt), 32'd5);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_vib", 32'(vib_cnt), 32'd0);
    check("clr_trem", 32'(trem), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_pos_trem", 32'(trem), 32'd0);

    // zero pulses with cen low: nothing moves.
    for (int i = 0; i < 37; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    snap_vib  = vib_m;
    snap_trem = trem_m;
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    check("cen_low_vib", 32'(vib_cnt), 32'(snap_vib));
    check("cen_low_trem", 32'(trem), 32'(snap_trem));

    // Asynchronous reset between edges with vib=3.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("vib_before_rst", 32'(vib_cnt), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_vib", 32'(vib_cnt), 32'd0);
    check("async_rst_trem", 32'(trem), 32'd0);
    #2;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("resume_vib", 32'(vib_cnt), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtopl_lfo.md
JTOPL_LFO -- requirements
Module: jtopl_lfo

Interface
- REQ-001 SHALL have parameter VIB_DIV_W, default 10: sample-counter width; vibrato advances once per 2^VIB_DIV_W samples.
- REQ-002 SHALL have parameter TREM_DIV_W, default 6: tremolo advances once per 2^TREM_DIV_W samples; SHALL be <= VIB_DIV_W.
- REQ-003 SHALL have parameter TREM_STEPS, default 210: tremolo position period; SHALL be even.
- REQ-004 SHALL have port clk, input, 1: single clock for all logic.
- REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
- REQ-006 SHALL have port cen, input, 1: clock enable; no state changes when low.
- REQ-007 SHALL have port zero, input, 1: sample-frame marker; a sample tick is cen && zero in the same cycle.
- REQ-008 SHALL have port lfo_clr, input, 1: synchronous clear of all LFO state, qualified by cen.
- REQ-009 SHALL have port fast, input, 1: test mode; every sample tick advances both vibrato and tremolo.
- REQ-010 SHALL have port am_dep, input, 1: tremolo depth; 1 selects deep (4.8 dB), 0 selects shallow (1.2 dB).
- REQ-011 SHALL have port vib_cnt, output, 3: vibrato phase for the phase-modulation stage.
- REQ-012 SHALL have port trem, output, 5: tremolo attenuation level for the envelope stage.

Function
- REQ-013 SHALL hold smp_cnt (VIB_DIV_W bits), which increments by 1 on each sample tick and wraps from 2^VIB_DIV_W-1 to 0.
- REQ-014 SHALL generate vib_step on a sample tick when smp_cnt is all-ones, or on any sample tick when fast=1.
- REQ-015 SHALL generate trem_step on a sample tick when smp_cnt[TREM_DIV_W-1:0] is all-ones, or on any sample tick when fast=1.
- REQ-016 SHALL increment vib_cnt modulo 8 on vib_step; sequence 0,1,...,7,0.
- REQ-017 SHALL hold trem_pos (8 bits, range 0..TREM_STEPS-1), which increments on trem_step and wraps from TREM_STEPS-1 to 0.
- REQ-018 SHALL compute tri = trem_pos when trem_pos < TREM_STEPS/2, otherwise TREM_STEPS-trem_pos; tri range is 0..105 at the default TREM_STEPS.
- REQ-019 SHALL register trem = tri>>2 when am_dep=1 (max 26), or tri>>4 when am_dep=0 (max 6).
- REQ-020 SHALL update trem one cycle after trem_pos or am_dep changes, with cen high; trem SHALL NOT change when cen is low.
- REQ-021 SHALL update vib_cnt on the clock edge of the sample tick, so it is visible the next cycle; latency SHALL be 1 cycle.
- REQ-022 SHALL give lfo_clr priority when lfo_clr and a sample tick coincide: smp_cnt, vib_cnt, trem_pos and trem are all forced to 0, and no increment occurs.
- REQ-023 SHALL NOT advance any counter on zero=1 with cen=0.
- REQ-024 SHALL keep smp_cnt counting while fast=1 and SHALL NOT cause a double step.

Reset
- REQ-025 SHALL on rst_n=0, asynchronously and regardless of clk or cen, force smp_cnt=0, vib_cnt=0, trem_pos=0 and trem=0.
- REQ-026 SHALL resume counting from zero at the first sample tick after rst_n deasserts.
- REQ-027 SHALL, when reset is asserted mid-frame, leave no partial step pending after release.

Verification
- REQ-028 Default parameters, fast=0, 1024 sample ticks -> vib_cnt goes 0->1 exactly after tick 1024; after 8192 ticks vib_cnt=0 again.
- REQ-029 fast=1, am_dep=1, 210 ticks -> trem rises 0..26, peaking at trem_pos=105 (trem=26), then falls back to 0; trem_pos=0 after tick 210.
- REQ-030 trem_pos=100, am_dep toggled 1->0 -> trem goes from 25 to 6 one cycle later.
- REQ-031 lfo_clr=1 together with a sample tick while vib_cnt=5 and trem_pos=150 -> next cycle all outputs and counters are 0.
- REQ-032 zero pulses with cen=0 for 2000 cycles -> smp_cnt, vib_cnt and trem are unchanged.
- REQ-033 rst_n pulsed low between clock edges with vib_cnt=3 -> vib_cnt=0 immediately, without waiting for a clock edge; counting resumes from 0.
